// File: rtl/noc_rx_vc_buffer_pkg.sv
// rtl/noc_rx_vc_buffer_pkg.sv - shared CONNECT parameters, flit/credit layouts and width helpers
package noc_rx_vc_buffer_pkg;

  localparam int NOC_NUM_VCS           = 2;
  localparam int NOC_DEST_BITS         = 2;
  localparam int NOC_FLIT_DATA_WIDTH   = 32;
  localparam int NOC_FLIT_BUFFER_DEPTH = 4;

  localparam int NOC_VC_BITS  = (NOC_NUM_VCS > 1) ? $clog2(NOC_NUM_VCS) : 1;
  localparam int NOC_FLIT_W   = 2 + NOC_DEST_BITS + NOC_VC_BITS + NOC_FLIT_DATA_WIDTH;
  localparam int NOC_CREDIT_W = 1 + NOC_VC_BITS;

  // Field offsets inside a flit, LSB first: {valid, tail, dest, vc, data}
  localparam int FLIT_DATA_LSB  = 0;
  localparam int FLIT_VC_LSB    = FLIT_DATA_LSB + NOC_FLIT_DATA_WIDTH;
  localparam int FLIT_DEST_LSB  = FLIT_VC_LSB + NOC_VC_BITS;
  localparam int FLIT_TAIL_POS  = FLIT_DEST_LSB + NOC_DEST_BITS;
  localparam int FLIT_VALID_POS = FLIT_TAIL_POS + 1;

  typedef struct packed {
    logic                           valid;
    logic                           tail;
    logic [NOC_DEST_BITS-1:0]       dest;
    logic [NOC_VC_BITS-1:0]         vc;
    logic [NOC_FLIT_DATA_WIDTH-1:0] data;
  } noc_flit_t;

  typedef struct packed {
    logic                   valid;
    logic [NOC_VC_BITS-1:0] vc;
  } noc_credit_t;

  // Pointer width for a circular buffer; a single-entry buffer still needs one bit
  function automatic int noc_ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// rtl/noc_vc_fifo.sv - single-VC circular flit FIFO with occupancy count
module noc_vc_fifo
  import noc_rx_vc_buffer_pkg::*;
#(
  parameter int WIDTH = NOC_FLIT_W,
  parameter int DEPTH = NOC_FLIT_BUFFER_DEPTH,
  parameter int PTR_W = noc_ptr_bits(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Explicit wrap keeps non-power-of-two depths correct
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage has no reset: contents are meaningless until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/noc_rx_vc_buffer.sv
// rtl/noc_rx_vc_buffer.sv - per-VC receive flit buffer with credit return to the router
module noc_rx_vc_buffer
  import noc_rx_vc_buffer_pkg::*;
#(
  parameter int NUM_VCS         = NOC_NUM_VCS,
  parameter int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  parameter int DEST_BITS       = NOC_DEST_BITS,
  parameter int FLIT_DATA_WIDTH = NOC_FLIT_DATA_WIDTH,
  parameter int BUF_DEPTH       = NOC_FLIT_BUFFER_DEPTH,
  parameter int FLIT_W          = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH,
  parameter int CREDIT_W        = 1 + VC_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [FLIT_W-1:0]   flit_in,
  output logic [CREDIT_W-1:0] credit_out,
  input  logic                deq_req,
  input  logic [VC_BITS-1:0]  deq_vc,
  output logic                deq_valid,
  output logic [FLIT_W-1:0]   deq_flit,
  output logic [NUM_VCS-1:0]  vc_nonempty,
  output logic                drop_err,
  output logic [31:0]         flits_rcvd
);

  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int VC_LSB = FLIT_DATA_WIDTH;

  logic               in_valid;
  logic [VC_BITS-1:0] in_vc;
  logic [NUM_VCS-1:0] push_sel;
  logic [NUM_VCS-1:0] pop_sel;
  logic [NUM_VCS-1:0] vc_full;
  logic [NUM_VCS-1:0] vc_empty;
  logic [CNT_W-1:0]   vc_count [NUM_VCS];
  logic [FLIT_W-1:0]  vc_rdata [NUM_VCS];
  logic [FLIT_W-1:0]  pop_data;
  logic               pop_fire;
  logic               push_ok;

  assign in_valid    = flit_in[FLIT_W-1];
  assign in_vc       = flit_in[VC_LSB +: VC_BITS];
  assign pop_fire    = |pop_sel;
  assign push_ok     = |push_sel;
  assign vc_nonempty = ~vc_empty;

  // Pop decode: only a VC holding data before this edge can be popped (no bypass)
  always_comb begin
    pop_sel = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (en && deq_req && (deq_vc == VC_BITS'(i)) && !vc_empty[i]) pop_sel[i] = 1'b1;
    end
  end

  // Push decode: a full VC still accepts when it is popped the same cycle;
  // an out-of-range VC matches no lane and is dropped
  always_comb begin
    push_sel = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (en && in_valid && (in_vc == VC_BITS'(i)) && (!vc_full[i] || pop_sel[i]))
        push_sel[i] = 1'b1;
    end
  end

  // Pop mux: select the head flit of the VC being popped
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (pop_sel[i]) pop_data = vc_rdata[i];
    end
  end

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
    noc_vc_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_sel[g]),
      .pop   (pop_sel[g]),
      .wdata (flit_in),
      .rdata (vc_rdata[g]),
      .count (vc_count[g]),
      .full  (vc_full[g]),
      .empty (vc_empty[g])
    );

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      vc_count[g] <= CNT_W'(BUF_DEPTH));
  end

  // A credit is only returned for a flit that was actually held, so credits never exceed accepted flits
  a_credit_backed: assert property (@(posedge clk) disable iff (!rst_n)
    (pop_sel & vc_empty) == '0);

  // Dequeue and credit outputs: one-cycle pulses registered from a successful pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deq_valid  <= 1'b0;
      deq_flit   <= '0;
      credit_out <= '0;
    end else if (pop_fire) begin
      deq_valid  <= 1'b1;
      deq_flit   <= pop_data;
      credit_out <= {1'b1, deq_vc};
    end else begin
      deq_valid  <= 1'b0;
      deq_flit   <= '0;
      credit_out <= '0;
    end
  end

  // Accepted-flit counter and sticky drop flag (any valid flit not stored, including while disabled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flits_rcvd <= '0;
      drop_err   <= 1'b0;
    end else begin
      if (push_ok)              flits_rcvd <= flits_rcvd + 32'd1;
      if (in_valid && !push_ok) drop_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_rx_vc_buffer.sv
// tb/tb_noc_rx_vc_buffer.sv - queue-model and directed checks for noc_rx_vc_buffer
module tb_noc_rx_vc_buffer;
  import noc_rx_vc_buffer_pkg::*;

  localparam int FW    = NOC_FLIT_W;
  localparam int CW    = NOC_CREDIT_W;
  localparam int DEPTH = NOC_FLIT_BUFFER_DEPTH;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic [FW-1:0]          flit_in = '0;
  logic                   deq_req = 1'b0;
  logic [NOC_VC_BITS-1:0] deq_vc = '0;
  logic [CW-1:0]          credit_out;
  logic                   deq_valid;
  logic [FW-1:0]          deq_flit;
  logic [NOC_NUM_VCS-1:0] vc_nonempty;
  logic                   drop_err;
  logic [31:0]            flits_rcvd;

  int n_checks = 0;
  int n_err    = 0;

  noc_rx_vc_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .flit_in     (flit_in),
    .credit_out  (credit_out),
    .deq_req     (deq_req),
    .deq_vc      (deq_vc),
    .deq_valid   (deq_valid),
    .deq_flit    (deq_flit),
    .vc_nonempty (vc_nonempty),
    .drop_err    (drop_err),
    .flits_rcvd  (flits_rcvd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural model: one FIFO queue per VC, outputs derived from queue occupancy
  logic [FW-1:0] q0[$];
  logic [FW-1:0] q1[$];
  logic          m_dv = 1'b0;
  logic [FW-1:0] m_flit = '0;
  logic [CW-1:0] m_credit = '0;
  logic          m_drop = 1'b0;
  logic [31:0]   m_rcvd = '0;

  function automatic int qsize(input int v);
    return (v == 0) ? q0.size() : q1.size();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    noc_flit_t f;
    int pv;
    int iv;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_dv = 1'b0; m_flit = '0; m_credit = '0; m_drop = 1'b0; m_rcvd = '0;
    end else begin
      f  = flit_in;
      pv = int'(deq_vc);
      iv = int'(f.vc);
      m_dv = 1'b0; m_flit = '0; m_credit = '0;
      if (en && deq_req && qsize(pv) > 0) begin
        if (pv == 0) m_flit = q0.pop_front();
        else         m_flit = q1.pop_front();
        m_dv = 1'b1;
        m_credit = {1'b1, deq_vc};
      end
      if (f.valid) begin
        if (en && iv < NOC_NUM_VCS && qsize(iv) < DEPTH) begin
          if (iv == 0) q0.push_back(flit_in);
          else         q1.push_back(flit_in);
          m_rcvd++;
        end else begin
          m_drop = 1'b1;
        end
      end
    end
  end

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("deq_valid", 64'(deq_valid), 64'(m_dv));
    chk("deq_flit", 64'(deq_flit), 64'(m_flit));
    chk("credit_out", 64'(credit_out), 64'(m_credit));
    chk("vc_nonempty", 64'(vc_nonempty), 64'({q1.size() != 0, q0.size() != 0}));
    chk("drop_err", 64'(drop_err), 64'(m_drop));
    chk("flits_rcvd", 64'(flits_rcvd), 64'(m_rcvd));
  end

  function automatic logic [FW-1:0] mk_flit(input logic tail, input int vc, input logic [31:0] data);
    noc_flit_t f;
    f.valid = 1'b1;
    f.tail  = tail;
    f.dest  = NOC_DEST_BITS'(vc + 1);
    f.vc    = NOC_VC_BITS'(vc);
    f.data  = data;
    return f;
  endfunction

  // Apply one cycle of inputs; returns 2 time units after the consuming edge
  task automatic cycle(input logic e, input logic fv, input logic tail, input int vc,
                       input logic [31:0] data, input logic rq, input int dvc);
    en      = e;
    flit_in = fv ? mk_flit(tail, vc, data) : '0;
    deq_req = rq;
    deq_vc  = NOC_VC_BITS'(dvc);
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int vc, input logic [31:0] data);
    cycle(1'b1, 1'b1, 1'b0, vc, data, 1'b0, 0);
  endtask

  task automatic pop(input int vc);
    cycle(1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b1, vc);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; flit_in = '0; deq_req = 1'b0; deq_vc = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic expect_deq(input string name, input logic v, input logic [31:0] data, input int vc);
    chk({name, ".valid"}, 64'(deq_valid), 64'(v));
    chk({name, ".data"}, 64'(deq_flit[31:0]), 64'(data));
    chk({name, ".credit"}, 64'(credit_out), v ? 64'({1'b1, NOC_VC_BITS'(vc)}) : 64'd0);
  endtask

  initial begin
    do_reset();
    chk("reset.deq_valid", 64'(deq_valid), 64'd0);
    chk("reset.credit", 64'(credit_out), 64'd0);
    chk("reset.nonempty", 64'(vc_nonempty), 64'd0);
    chk("reset.rcvd", 64'(flits_rcvd), 64'd0);

    // In-order delivery on vc0
    push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
    cycle(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 0);
    pop(0); expect_deq("t1.p0", 1'b1, 32'h11, 0);
    pop(0); expect_deq("t1.p1", 1'b1, 32'h22, 0);
    pop(0); expect_deq("t1.p2", 1'b1, 32'h33, 0);
    chk("t1.nonempty", 64'(vc_nonempty), 64'd0);
    chk("t1.rcvd", 64'(flits_rcvd), 64'd3);

    // Overflow on vc1 drops the extra flit
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 32'hA0 + 32'(i));
    push(1, 32'hFF);
    chk("t2.drop", 64'(drop_err), 64'd1);
    chk("t2.nonempty", 64'(vc_nonempty), 64'b10);
    chk("t2.rcvd", 64'(flits_rcvd), 64'd4);
    for (int i = 0; i < 4; i++) begin
      pop(1);
      expect_deq("t2.pop", 1'b1, 32'hA0 + 32'(i), 1);
    end
    pop(1); expect_deq("t2.empty", 1'b0, 32'h0, 0);

    // Full vc1: simultaneous push and pop both accepted
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 32'hB0 + 32'(i));
    cycle(1'b1, 1'b1, 1'b0, 1, 32'hAA, 1'b1, 1);
    expect_deq("t3.pp", 1'b1, 32'hB0, 1);
    chk("t3.drop", 64'(drop_err), 64'd0);
    for (int i = 1; i < 4; i++) begin
      pop(1);
      expect_deq("t3.pop", 1'b1, 32'hB0 + 32'(i), 1);
    end
    pop(1); expect_deq("t3.last", 1'b1, 32'hAA, 1);

    // Empty vc0: no bypass of a same-cycle push
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 0, 32'h55, 1'b1, 0);
    expect_deq("t4.nobypass", 1'b0, 32'h0, 0);
    pop(0); expect_deq("t4.pop", 1'b1, 32'h55, 0);

    // Interleaved VCs, tail bits carried through
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 0, 32'h1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 1, 32'h2, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 0, 32'h3, 1'b0, 0);
    pop(1); expect_deq("t5.v1", 1'b1, 32'h2, 1);
    chk("t5.tail2", 64'(deq_flit[FLIT_TAIL_POS]), 64'd1);
    pop(0); expect_deq("t5.v0a", 1'b1, 32'h1, 0);
    chk("t5.tail1", 64'(deq_flit[FLIT_TAIL_POS]), 64'd0);
    pop(0); expect_deq("t5.v0b", 1'b1, 32'h3, 0);
    chk("t5.tail3", 64'(deq_flit[FLIT_TAIL_POS]), 64'd1);
    chk("t5.dest", 64'(deq_flit[FLIT_DEST_LSB +: NOC_DEST_BITS]), 64'd1);

    // Asynchronous reset mid-cycle, then en=0 drop
    do_reset();
    push(0, 32'h61); push(0, 32'h62);
    pop(0); expect_deq("t6.pre", 1'b1, 32'h61, 0);
    #1;
    rst_n = 1'b0; en = 1'b0; flit_in = '0; deq_req = 1'b0;
    #1;
    chk("t6.rst.valid", 64'(deq_valid), 64'd0);
    chk("t6.rst.flit", 64'(deq_flit), 64'd0);
    chk("t6.rst.credit", 64'(credit_out), 64'd0);
    chk("t6.rst.nonempty", 64'(vc_nonempty), 64'd0);
    chk("t6.rst.rcvd", 64'(flits_rcvd), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pop(0); expect_deq("t6.nocredit", 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0, 32'h77, 1'b0, 0);
    chk("t6.en0.drop", 64'(drop_err), 64'd1);
    chk("t6.en0.rcvd", 64'(flits_rcvd), 64'd0);
    chk("t6.en0.nonempty", 64'(vc_nonempty), 64'd0);
    cycle(1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
